uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` instance between `N_REQ` byte-stream requesters. It grants the transmitter to one requester for a whole packet and prefixes each packet with a header byte identifying the source. It drives `uart_tx`'s `start_tx`/`data_to_tx` and paces itself on `tx_busy`. The block sits between the control-side producers (status, telemetry, debug) and the single UART link on the FPGA.

## Interface
- `N_REQ`, 4: number of requesters; 2..8.
- `MAX_LEN`, 16: maximum payload bytes per packet; 1..255.
- `GAP_TIMEOUT`, 1024: clk cycles allowed between payload bytes before the packet is aborted.
- `HDR_TAG`, 5'b10100: upper 5 bits of the header byte.

- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: requester i has a byte on its `req_data` lane.
- `req_data` in 8*N_REQ: byte lane i is bits [8i+7:8i].
- `req_last` in N_REQ: the byte on lane i is the last of its packet.
- `req_ack` out N_REQ: one-cycle pulse; byte on lane i consumed.
- `grant` out N_REQ: one-hot owner of the transmitter, held for the whole packet.
- `tx_busy` in 1: from `uart_tx`.
- `start_tx` out 1: to `uart_tx`, one-cycle pulse.
- `data_to_tx` out 8: to `uart_tx`; valid in the `start_tx` cycle.
- `busy` out 1: a packet is in progress.
- `pkt_done` out 1: one-cycle pulse on normal packet end.
- `err` out 2: one-cycle code. 01 means timeout abort. 10 means MAX_LEN truncation.

## Operation
- Reset values: all outputs 0 and state IDLE. The round-robin pointer is set to N_REQ-1, so requester 0 wins first.
- States and transitions:
  - IDLE: waits for any `req_valid`. The winner is the first set bit scanning upward from pointer+1 (mod N_REQ).
  - HDR: grant[w]=1 and pulse `start_tx` with `data_to_tx` = {HDR_TAG, w[2:0]}. Go to WAIT_HI.
  - WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO.
  - WAIT_LO: wait for `tx_busy`=0, then go to FETCH, or go to END if the last byte was sent or the count reached MAX_LEN.
  - FETCH: if `req_valid[w]`, pulse `start_tx` with `data_to_tx`=lane w and `req_ack[w]` in the same cycle, latch `req_last[w]`, increment the byte count, and go to WAIT_HI. Otherwise increment the gap counter; when it reaches GAP_TIMEOUT, go to END with abort.
  - END: clear `grant` and `busy`, set pointer := w, pulse `pkt_done` (normal end) or `err` (abort or truncation), and go to IDLE.
- `start_tx` is never asserted while `tx_busy`=1 or in consecutive cycles.
- Only the granted lane is ever acked. Other requesters' `req_valid` is ignored until END.
- Truncation: after MAX_LEN payload bytes without `req_last`, the packet ends with err=10. The requester's remaining bytes start a new packet when it next wins arbitration.
- The byte count is 8 bits and the gap counter is $clog2(GAP_TIMEOUT+1) bits. Both clear in HDR and the gap counter also clears on every ack; neither wraps.
- Reset mid-packet: all outputs drop to 0 immediately (asynchronously). The partial UART frame is the transmitter's concern.

## Timing
- Idle to header: `req_valid` seen in cycle t gives `grant` and `start_tx` at t+1.
- Inter-byte: the cycle after `tx_busy` falls is FETCH. If data is valid, `start_tx` and `req_ack` occur in that cycle, giving 1 cycle of dead time after `tx_busy` falls.
- Packet end: the cycle after the final `tx_busy` fall is END (`pkt_done`). A new grant can occur at the earliest on the following cycle.
- `busy` is high from the HDR cycle through the END cycle, inclusive.
- The design tolerates `tx_busy` rising any number of cycles after `start_tx`; there is no timeout in WAIT_HI.

## Test plan
- Single packet: requester 2 sends 3 bytes 0x11, 0x22, 0x33 (last on 0x33). UART stream must be 0xA2, 0x11, 0x22, 0x33, then one `pkt_done` pulse and three `req_ack[2]` pulses.
- Round-robin: requesters 0 and 1 both hold 1-byte packets continuously. Headers must alternate 0xA0, 0xA1, 0xA0, starting with 0xA0 after reset.
- Lock: requester 3 starts a 4-byte packet; requester 0 raises valid after the header. Requester 0's header must appear only after requester 3's `pkt_done`.
- Timeout: with GAP_TIMEOUT=8, requester 1 drops valid after its first byte. `err`=01 must pulse 8 cycles into FETCH, `grant` must clear, and no further ack is given.
- Truncation: with MAX_LEN=2, send 3 bytes without `req_last` until the third. Expect err=10 after 2 bytes, then a new header 0xA1 followed by the third byte.
- Reset during WAIT_LO: assert reset low asynchronously. `grant`, `busy`, and `start_tx` must be 0 within the same cycle, and after release the arbiter must restart from requester 0 priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared uart_tx: one requester holds the transmitter for a
// whole packet, which is prefixed by a header byte {HDR_TAG, source index}.
//
// state   | meaning
// IDLE    | no packet; pick the next requester after the pointer
// HDR     | send the header byte for the granted requester
// WAIT_HI | byte handed to uart_tx, waiting for tx_busy to rise
// WAIT_LO | byte in flight, waiting for tx_busy to fall
// FETCH   | take the next payload byte from the granted lane, or time out
// END     | report done/abort/truncation, move the pointer, release grant
module uart_tx_arbiter #(
    parameter int         N_REQ       = 4,
    parameter int         MAX_LEN     = 16,
    parameter int         GAP_TIMEOUT = 1024,
    parameter logic [4:0] HDR_TAG     = 5'b10100
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [N_REQ-1:0]   grant_o,
    input  logic               tx_busy_i,
    output logic               start_tx_o,
    output logic [7:0]         data_to_tx_o,
    output logic               busy_o,
    output logic               pkt_done_o,
    output logic [1:0]         err_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR     = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_FETCH   = 3'd4;
    localparam logic [2:0] S_END     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_q, win_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          last_q, last_d;
    logic          abort_q, abort_d;

    logic          any_req;
    logic [IW-1:0] pick;
    logic          fire;

    // First requesting lane scanning upward from the lane after the pointer.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!any_req && req_valid_i[(int'(ptr_q) + i) % N_REQ]) begin
                any_req = 1'b1;
                pick    = IW'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    assign fire = (state_q == S_FETCH) && req_valid_i[win_q] && !tx_busy_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        last_d  = last_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    win_d   = pick;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                cnt_d   = '0;
                gap_d   = '0;
                last_d  = 1'b0;
                abort_d = 1'b0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy_i) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!tx_busy_i) begin
                    if (last_q || (cnt_q == 8'(MAX_LEN))) state_d = S_END;
                    else                                  state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fire) begin
                    last_d  = req_last_i[win_q];
                    cnt_d   = cnt_q + 8'd1;
                    gap_d   = '0;
                    state_d = S_WAIT_HI;
                end else begin
                    gap_d = gap_q + 1'b1;
                    if (gap_q == GW'(GAP_TIMEOUT - 1)) begin
                        abort_d = 1'b1;
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                ptr_d   = win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from state so an asynchronous reset clears them at once.
    always_comb begin
        start_tx_o   = 1'b0;
        data_to_tx_o = '0;
        req_ack_o    = '0;
        grant_o      = '0;
        busy_o       = 1'b0;
        pkt_done_o   = 1'b0;
        err_o        = 2'b00;
        if (state_q != S_IDLE) begin
            busy_o         = 1'b1;
            grant_o[win_q] = 1'b1;
        end
        case (state_q)
            S_HDR: begin
                start_tx_o   = 1'b1;
                data_to_tx_o = {HDR_TAG, 3'(win_q)};
            end
            S_FETCH: begin
                if (fire) begin
                    start_tx_o       = 1'b1;
                    data_to_tx_o     = req_data_i[8*win_q +: 8];
                    req_ack_o[win_q] = 1'b1;
                end
            end
            S_END: begin
                if (abort_q)     err_o      = 2'b01;
                else if (last_q) pkt_done_o = 1'b1;
                else             err_o      = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(N_REQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            last_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            last_q  <= last_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-fed requesters, a uart_tx busy model and
// a scoreboard of expected UART bytes. Two instances differ only in MAX_LEN.
module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int BUSY_LEN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           sel;
    logic [N-1:0]   req_valid, req_last;
    logic [8*N-1:0] req_data;
    logic           tx_busy;

    logic [N-1:0] ack_a, grant_a, ack_b, grant_b;
    logic         start_a, start_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]   data_a, data_b;
    logic [1:0]   err_a, err_b;

    logic [N-1:0] ack_m, grant_m;
    logic         start_m, busy_m, done_m;
    logic [7:0]   data_m;
    logic [1:0]   err_m;

    assign ack_m   = sel ? ack_b   : ack_a;
    assign grant_m = sel ? grant_b : grant_a;
    assign start_m = sel ? start_b : start_a;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign done_m  = sel ? done_b  : done_a;
    assign data_m  = sel ? data_b  : data_a;
    assign err_m   = sel ? err_b   : err_a;

    uart_tx_arbiter #(.N_REQ(N), .MAX_LEN(16), .GAP_TIMEOUT(8), .HDR_TAG(5'b10100)) dut_a (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ack_o(ack_a), .grant_o(grant_a), .tx_busy_i(tx_busy),
        .start_tx_o(start_a), .data_to_tx_o(data_a), .busy_o(busy_a),
        .pkt_done_o(done_a), .err_o(err_a)
    );

    uart_tx_arbiter #(.N_REQ(N), .MAX_LEN(2), .GAP_TIMEOUT(8), .HDR_TAG(5'b10100)) dut_b (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ack_o(ack_b), .grant_o(grant_b), .tx_busy_i(tx_busy),
        .start_tx_o(start_b), .data_to_tx_o(data_b), .busy_o(busy_b),
        .pkt_done_o(done_b), .err_o(err_b)
    );

    // uart_tx model: busy for BUSY_LEN cycles starting the cycle after start_tx.
    int bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bcnt <= 0;
        else if (start_m)    bcnt <= BUSY_LEN;
        else if (bcnt != 0)  bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    // Requester sources: per-lane byte FIFOs, popped on ack.
    logic [8:0]   mem [N][32];
    int           wr [N];
    int           rd [N];
    logic [N-1:0] en, flush;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = en[i] && (rd[i] < wr[i]);
            req_data[8*i +: 8] = mem[i][rd[i] % 32][7:0];
            req_last[i]        = mem[i][rd[i] % 32][8];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (flush[i])      rd[i] <= wr[i];
            else if (ack_m[i]) rd[i] <= rd[i] + 1;
        end
    end

    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    int checks   = 0;
    int failures = 0;
    int ack_cnt [N] = '{default: 0};
    int done_cnt = 0, err1_cnt = 0, err2_cnt = 0, hdr_done_snap = 0;
    logic start_prev = 1'b0;

    // Output monitor: scoreboard of UART bytes plus protocol rules.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                start_prev = 1'b0;
            end else begin
                if (start_m) begin
                    checks++;
                    assert (!tx_busy && !start_prev) else begin
                        failures++;
                        $error("FAIL start_rule busy=%0b prev_start=%0b exp=0/0", tx_busy, start_prev);
                    end
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        failures++;
                        $error("FAIL sb_extra got=%02h exp=none", data_m);
                    end
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        checks++;
                        assert (data_m === exp_b) else begin
                            failures++;
                            $error("FAIL sb_byte got=%02h exp=%02h", data_m, exp_b);
                        end
                    end
                    if (data_m[7:3] == 5'b10100) hdr_done_snap = done_cnt;
                end
                if (ack_m != '0) begin
                    checks++;
                    assert ($onehot(ack_m) && ((ack_m & ~grant_m) == '0)) else begin
                        failures++;
                        $error("FAIL ack_lane ack=%b grant=%b exp=onehot_in_grant", ack_m, grant_m);
                    end
                    for (int i = 0; i < N; i++) if (ack_m[i]) ack_cnt[i]++;
                end
                if (done_m)          done_cnt++;
                if (err_m == 2'b01)  err1_cnt++;
                if (err_m == 2'b10)  err2_cnt++;
                start_prev = start_m;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][wr[r] % 32] = {l, d};
        wr[r] = wr[r] + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy_m) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size() == 0 && !busy_m), 32'd1);
    endtask

    task automatic wait_start(input string tag, input logic [7:0] v, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(start_m && data_m == v) && n < budget);
        chk(tag, 32'(start_m && data_m == v), 32'd1);
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_busy != lvl && n < budget);
        chk(tag, 32'(tx_busy), 32'(lvl));
    endtask

    initial begin
        int d0, e1, e2, a1, a2, n;
        rst_n = 1'b0;
        sel   = 1'b0;
        en    = '0;
        flush = '0;
        foreach (wr[i]) wr[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_start", 32'(start_m), 32'd0);
        chk("rst_data", 32'(data_m), 32'd0);
        chk("rst_ack", 32'(ack_m), 32'd0);
        chk("rst_flags", 32'({done_m, err_m}), 32'd0);
        step();
        rst_n = 1'b1;

        // single packet from requester 2, with idle-to-header latency
        step();
        push(2, 8'h11, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h33, 1'b1);
        exp_q.push_back(8'hA2); exp_q.push_back(8'h11);
        exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        d0 = done_cnt; a2 = ack_cnt[2];
        en[2] = 1'b1;
        @(negedge clk);
        chk("t1_idle_cycle_grant", 32'(grant_m), 32'd0);
        @(negedge clk);
        chk("t1_hdr_grant", 32'(grant_m), 32'b0100);
        chk("t1_hdr_start", 32'(start_m), 32'd1);
        chk("t1_hdr_busy", 32'(busy_m), 32'd1);
        wait_drain("t1_drain", 200);
        chk("t1_done", 32'(done_cnt - d0), 32'd1);
        chk("t1_acks", 32'(ack_cnt[2] - a2), 32'd3);
        chk("t1_no_err", 32'(err1_cnt + err2_cnt), 32'd0);

        // round robin between requesters 0 and 1
        step();
        push(0, 8'h50, 1'b1); push(0, 8'h51, 1'b1);
        push(1, 8'h60, 1'b1); push(1, 8'h61, 1'b1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h50);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h60);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h51);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h61);
        d0 = done_cnt;
        en[0] = 1'b1; en[1] = 1'b1;
        wait_drain("t2_drain", 400);
        chk("t2_done", 32'(done_cnt - d0), 32'd4);

        // lock: requester 0 arrives during requester 3's packet
        step();
        en[0] = 1'b0;
        push(3, 8'h70, 1'b0); push(3, 8'h71, 1'b0);
        push(3, 8'h72, 1'b0); push(3, 8'h73, 1'b1);
        push(0, 8'h80, 1'b1);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h70); exp_q.push_back(8'h71);
        exp_q.push_back(8'h72); exp_q.push_back(8'h73);
        exp_q.push_back(8'hA0); exp_q.push_back(8'h80);
        d0 = done_cnt;
        en[3] = 1'b1;
        wait_start("t3_hdr3", 8'hA3, 20);
        step();
        en[0] = 1'b1;
        wait_drain("t3_drain", 400);
        chk("t3_hdr0_after_done", 32'(hdr_done_snap - d0), 32'd1);
        chk("t3_done", 32'(done_cnt - d0), 32'd2);

        // gap timeout after requester 1's first byte
        step();
        push(1, 8'h90, 1'b0);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h90);
        e1 = err1_cnt; a1 = ack_cnt[1]; d0 = done_cnt;
        wait_start("t4_byte", 8'h90, 40);
        wait_busy("t4_busy_hi", 1'b1, 10);
        wait_busy("t4_busy_lo", 1'b0, 20);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (err_m == 2'b00 && n < 20);
        chk("t4_abort_latency", 32'(n), 32'd9);
        chk("t4_abort_code", 32'(err_m), 32'd1);
        @(negedge clk);
        chk("t4_grant_clear", 32'(grant_m), 32'd0);
        chk("t4_busy_clear", 32'(busy_m), 32'd0);
        repeat (5) @(negedge clk);
        chk("t4_acks", 32'(ack_cnt[1] - a1), 32'd1);
        chk("t4_err_cnt", 32'(err1_cnt - e1), 32'd1);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);

        // truncation on the MAX_LEN=2 instance
        step();
        rst_n = 1'b0; sel = 1'b1; en = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h33);
        e2 = err2_cnt; d0 = done_cnt; a1 = ack_cnt[1];
        en[1] = 1'b1;
        wait_drain("t5_drain", 400);
        chk("t5_trunc", 32'(err2_cnt - e2), 32'd1);
        chk("t5_done", 32'(done_cnt - d0), 32'd1);
        chk("t5_acks", 32'(ack_cnt[1] - a1), 32'd3);

        // asynchronous reset in WAIT_LO, then priority restarts at requester 0
        step();
        rst_n = 1'b0; sel = 1'b0; en = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        push(0, 8'hE0, 1'b1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hE0);
        en[0] = 1'b1;
        wait_drain("t6_pre_drain", 200);
        step();
        push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
        exp_q.push_back(8'hA2);
        en[2] = 1'b1;
        wait_start("t6_hdr", 8'hA2, 20);
        wait_busy("t6_busy_hi", 1'b1, 10);
        @(negedge clk);
        chk("t6_in_packet", 32'(busy_m), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant_m), 32'd0);
        chk("t6_rst_busy", 32'(busy_m), 32'd0);
        chk("t6_rst_start", 32'(start_m), 32'd0);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);
        flush = '1; en = '0;
        step();
        flush = '0;
        step();
        rst_n = 1'b1;
        step();
        push(3, 8'hD0, 1'b1); push(0, 8'hD1, 1'b1);
        exp_q.push_back(8'hA0); exp_q.push_back(8'hD1);
        exp_q.push_back(8'hA3); exp_q.push_back(8'hD0);
        en = 4'b1001;
        wait_drain("t6_drain", 400);

        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
